// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared ALU op codes, RV32I opcode/funct constants and the
//             instruction decode helper used by the issue stage.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int OPW = 6;

   // ALU op encoding
   localparam logic [OPW-1:0] OP_NOP  = 6'd0;
   localparam logic [OPW-1:0] OP_ADD  = 6'd1;
   localparam logic [OPW-1:0] OP_SUB  = 6'd2;
   localparam logic [OPW-1:0] OP_AND  = 6'd3;
   localparam logic [OPW-1:0] OP_OR   = 6'd4;
   localparam logic [OPW-1:0] OP_XOR  = 6'd5;
   localparam logic [OPW-1:0] OP_SLT  = 6'd6;
   localparam logic [OPW-1:0] OP_SLTU = 6'd7;
   localparam logic [OPW-1:0] OP_SLL  = 6'd8;
   localparam logic [OPW-1:0] OP_SRL  = 6'd9;
   localparam logic [OPW-1:0] OP_SRA  = 6'd10;

   // RV32I major opcodes handled by this stage
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;

   // funct3 values
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // funct7 values
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // First operand source
   typedef enum logic [0:0] {
      S1_ZERO = 1'b0,
      S1_REG  = 1'b1
   } src1_e;

   // Second operand source
   typedef enum logic [2:0] {
      S2_ZERO   = 3'd0,
      S2_REG    = 3'd1,
      S2_REG_SH = 3'd2,
      S2_IMM_I  = 3'd3,
      S2_SHAMT  = 3'd4,
      S2_IMM_U  = 3'd5
   } src2_e;

   typedef struct packed {
      logic           legal;
      logic [OPW-1:0] op;
      src1_e          src1;
      src2_e          src2;
   } dec_t;

   // Map an instruction word onto ALU op and operand sources.
   // Anything not recognised comes back illegal with NOP and zero operands.
   function automatic dec_t decode(input logic [31:0] instr);
      dec_t       d;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      opc     = instr[6:0];
      f3      = instr[14:12];
      f7      = instr[31:25];
      d.legal = 1'b0;
      d.op    = OP_NOP;
      d.src1  = S1_ZERO;
      d.src2  = S2_ZERO;
      case (opc)
         OPC_OP: begin
            if (f7 == F7_BASE) begin
               d.legal = 1'b1;
               d.src1  = S1_REG;
               d.src2  = S2_REG;
               case (f3)
                  F3_ADD:  d.op = OP_ADD;
                  F3_SLL:  begin d.op = OP_SLL; d.src2 = S2_REG_SH; end
                  F3_SLT:  d.op = OP_SLT;
                  F3_SLTU: d.op = OP_SLTU;
                  F3_XOR:  d.op = OP_XOR;
                  F3_SR:   begin d.op = OP_SRL; d.src2 = S2_REG_SH; end
                  F3_OR:   d.op = OP_OR;
                  default: d.op = OP_AND;
               endcase
            end else if (f7 == F7_ALT && f3 == F3_ADD) begin
               d.legal = 1'b1;
               d.op    = OP_SUB;
               d.src1  = S1_REG;
               d.src2  = S2_REG;
            end else if (f7 == F7_ALT && f3 == F3_SR) begin
               d.legal = 1'b1;
               d.op    = OP_SRA;
               d.src1  = S1_REG;
               d.src2  = S2_REG_SH;
            end
         end
         OPC_OPIMM: begin
            case (f3)
               F3_ADD:  begin d.legal = 1'b1; d.op = OP_ADD;  end
               F3_SLT:  begin d.legal = 1'b1; d.op = OP_SLT;  end
               F3_SLTU: begin d.legal = 1'b1; d.op = OP_SLTU; end
               F3_XOR:  begin d.legal = 1'b1; d.op = OP_XOR;  end
               F3_OR:   begin d.legal = 1'b1; d.op = OP_OR;   end
               F3_AND:  begin d.legal = 1'b1; d.op = OP_AND;  end
               F3_SLL: begin
                  if (f7 == F7_BASE) begin
                     d.legal = 1'b1;
                     d.op    = OP_SLL;
                  end
               end
               default: begin
                  if (f7 == F7_BASE) begin
                     d.legal = 1'b1;
                     d.op    = OP_SRL;
                  end else if (f7 == F7_ALT) begin
                     d.legal = 1'b1;
                     d.op    = OP_SRA;
                  end
               end
            endcase
            if (d.legal) begin
               d.src1 = S1_REG;
               d.src2 = (f3 == F3_SLL || f3 == F3_SR) ? S2_SHAMT : S2_IMM_I;
            end
         end
         OPC_LUI: begin
            d.legal = 1'b1;
            d.op    = OP_ADD;
            d.src1  = S1_ZERO;
            d.src2  = S2_IMM_U;
         end
         default: begin
            d.legal = 1'b0;
         end
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_2r1w
//  Brief    : 32-bit register file, two combinational read ports plus a debug
//             read port, one synchronous write port; entry 0 reads as zero.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
   parameter int NREG = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ra1_i,
   output logic [31:0] rd1_o,
   input  logic [4:0]  ra2_i,
   output logic [31:0] rd2_o,
   input  logic [4:0]  dbg_addr_i,
   output logic [31:0] dbg_data_o,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i
);

   logic [31:0] w_regs [NREG];

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign w_regs[gi] = 32'd0;
         end else begin : g_store
            logic [31:0] entry_q;
            // Entry captures write data when addressed; cleared on reset.
            always_ff @(posedge clk or negedge reset) begin
               if (!reset) begin
                  entry_q <= 32'd0;
               end else if (we_i && (wa_i == 5'(gi))) begin
                  entry_q <= wd_i;
               end
            end
            assign w_regs[gi] = entry_q;
         end
      end
   endgenerate

   assign rd1_o      = w_regs[ra1_i];
   assign rd2_o      = w_regs[ra2_i];
   assign dbg_data_o = w_regs[dbg_addr_i];

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue
//  Brief    : RV32I OP / OP-IMM / LUI decode-and-issue stage in front of a
//             combinational ALU; reads operands, forwards the retiring
//             result, registers op/rv1/rv2 and writes the result back.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue #(
   parameter int OPW  = 6,
   parameter int NREG = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [31:0]    in_instr,
   output logic [OPW-1:0] op,
   output logic [31:0]    rv1,
   output logic [31:0]    rv2,
   output logic           alu_valid,
   input  logic           alu_ready,
   input  logic [31:0]    alu_result,
   output logic           wb_en,
   output logic [4:0]     wb_rd,
   output logic [31:0]    wb_data,
   output logic           illegal,
   input  logic [4:0]     dbg_addr,
   output logic [31:0]    dbg_data
);

   import alu_pkg::*;

   // Held instruction state
   logic [OPW-1:0] op_q;
   logic [31:0]    rv1_q;
   logic [31:0]    rv2_q;
   logic           valid_q;
   logic [4:0]     rd_q;
   logic           legal_q;
   logic           illegal_q;

   // Next operand values for an accepted instruction
   logic [31:0]    rv1_d;
   logic [31:0]    rv2_d;

   dec_t           w_dec;
   logic [4:0]     w_rs1;
   logic [4:0]     w_rs2;
   logic [31:0]    w_rf1;
   logic [31:0]    w_rf2;
   logic [31:0]    w_src1;
   logic [31:0]    w_src2;
   logic           w_accept;
   logic           w_retire;
   logic           w_wb_en;

   assign w_dec    = decode(in_instr);
   assign w_rs1    = in_instr[19:15];
   assign w_rs2    = in_instr[24:20];

   assign in_ready = !valid_q || alu_ready;
   assign w_accept = in_valid && in_ready;
   assign w_retire = valid_q && alu_ready;

   // rd_q is zeroed for illegal instructions, so rd != 0 implies legal here
   assign w_wb_en  = w_retire && legal_q && (rd_q != 5'd0);

   regfile_2r1w #(
      .NREG (NREG)
   ) u_rf (
      .clk        (clk),
      .reset      (reset),
      .ra1_i      (w_rs1),
      .rd1_o      (w_rf1),
      .ra2_i      (w_rs2),
      .rd2_o      (w_rf2),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data),
      .we_i       (w_wb_en),
      .wa_i       (rd_q),
      .wd_i       (alu_result)
   );

   // Bypass the result being written this cycle; wb_en already excludes x0.
   assign w_src1 = (w_wb_en && (w_rs1 == rd_q)) ? alu_result : w_rf1;
   assign w_src2 = (w_wb_en && (w_rs2 == rd_q)) ? alu_result : w_rf2;

   // Operand selection for the instruction being accepted.
   always_comb begin
      rv1_d = 32'd0;
      rv2_d = 32'd0;
      if (w_dec.src1 == S1_REG) begin
         rv1_d = w_src1;
      end
      case (w_dec.src2)
         S2_REG:    rv2_d = w_src2;
         S2_REG_SH: rv2_d = {27'd0, w_src2[4:0]};
         S2_IMM_I:  rv2_d = {{20{in_instr[31]}}, in_instr[31:20]};
         S2_SHAMT:  rv2_d = {27'd0, in_instr[24:20]};
         S2_IMM_U:  rv2_d = {in_instr[31:12], 12'd0};
         default:   rv2_d = 32'd0;
      endcase
   end

   // Issue register: load on accept, drain on retire, hold while stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q   <= 1'b0;
         op_q      <= '0;
         rv1_q     <= 32'd0;
         rv2_q     <= 32'd0;
         rd_q      <= 5'd0;
         legal_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= w_retire && !legal_q;
         if (w_accept) begin
            valid_q <= 1'b1;
            op_q    <= OPW'(w_dec.op);
            rv1_q   <= rv1_d;
            rv2_q   <= rv2_d;
            rd_q    <= w_dec.legal ? in_instr[11:7] : 5'd0;
            legal_q <= w_dec.legal;
         end else if (w_retire) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            rv1_q   <= 32'd0;
            rv2_q   <= 32'd0;
            rd_q    <= 5'd0;
            legal_q <= 1'b0;
         end
      end
   end

   assign op        = op_q;
   assign rv1       = rv1_q;
   assign rv2       = rv2_q;
   assign alu_valid = valid_q;
   assign illegal   = illegal_q;
   assign wb_en     = w_wb_en;
   assign wb_rd     = rd_q;
   assign wb_data   = alu_result;

endmodule
`default_nettype wire
